result_unloader: RTL and testbench
==================================

Name: result_unloader

Overview:
- Reader side of the per-core result write path into data memory.
- Arms on begin_process and collects the end_process flag of each core; the flag may be a pulse or a level.
- Once every core has finished, reads the result matrix out of data memory through a dedicated read port.
- Streams the matrix to the host one word at a time over a valid/ready handshake.

Parameters:
DATA_W, 16, width of a data-memory word
ADDR_W, 16, width of a data-memory address
N_CORES, 4, number of processor cores whose end_process must be seen
BASE_ADDR, 16'd64, address of the first result word
N_WORDS, 16, number of result words to unload (4x4 matrix)

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
begin_process  in  1  arm pulse, same signal that starts the cores
end_process  in  N_CORES  per-core completion, bit i = core i
rd_en  out  1  data-memory read strobe
rd_addr  out  ADDR_W  data-memory read address
rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
out_data  out  DATA_W  streamed result word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts the word when out_valid && out_ready
out_last  out  1  high with the final word (index N_WORDS-1)
busy  out  1  high in any state except IDLE and DONE
done  out  1  high in DONE until the next arm

Behaviour:
- Interface is fixed: one clock (clock); reset is synchronous and active-low (resetn).
- Reset (resetn=0 at posedge), taking priority over everything:
  - state=IDLE.
  - All outputs 0; rd_addr=BASE_ADDR.
  - Sticky done flags cleared; word counter cleared.
- Sticky flags: flag[i] is set on any cycle with end_process[i]=1 and cleared only by reset or arm.
- Arm: begin_process=1 in any state other than reset does the following, aborting any unload in progress:
  - clears flags and counter;
  - deasserts out_valid, done and rd_en;
  - enters WAIT_CORES on the next cycle.
  - end_process bits high in the arm cycle are ignored; they count from the next cycle.
- States:
  - IDLE: wait for arm.
  - WAIT_CORES: when all flags are set (including bits set this cycle) -> ISSUE.
  - ISSUE: rd_en=1 for exactly 1 cycle, rd_addr=BASE_ADDR+count -> WAIT_DATA.
  - WAIT_DATA: capture rd_data into out_data, set out_valid -> HOLD.
  - HOLD: hold out_data and out_valid stable until out_ready=1.
    - On the handshake, if count==N_WORDS-1 -> DONE.
    - Otherwise count++ and go to ISSUE (out_valid drops the next cycle).
  - DONE: done=1, busy=0; stays until arm or reset.
- Throughput is at most 1 word per 3 cycles. Latency from the last flag to the first out_valid is 3 cycles: WAIT_CORES->ISSUE->WAIT_DATA->HOLD.
- out_last=out_valid && (count==N_WORDS-1).
- Address arithmetic is modulo 2^ADDR_W and wraps silently. The counter is $clog2(N_WORDS)+1 bits, so N_WORDS=1 is legal.
- out_ready high while out_valid=0 has no effect. out_valid never drops without a handshake, except on arm or reset.
- end_process seen while in IDLE or DONE only sets flags; it has no other effect.

Decomposition:
- Package result_unloader_pkg holds:
  - state enum: IDLE, WAIT_CORES, ISSUE, WAIT_DATA, HOLD, DONE;
  - default constants BASE_ADDR and N_WORDS.
- Sub-module core_done_tracker (parameter N_CORES) holds the sticky flags. Inputs: clock, resetn, clear, end_process. Output: all_done, combinational over flags | end_process.

Test Plan:
- Arm; pulse end_process=0001, 0010, 0100, 1000 on separate cycles. Memory holds mem[64+k]=k*3. Hold out_ready=1. Expect 16 words 0,3,...,45; rd_addr 64..79; out_last only on 45; then done=1, busy=0.
- Drive end_process=1111 as a level 1 cycle after arm. Expect the first rd_en 1 cycle later and the first out_valid 3 cycles after the flags complete.
- Hold out_ready=0 for 5 cycles on word 2. Expect out_data stable at 6 and out_valid=1 throughout, no rd_en, and word 3 read only after the handshake.
- Only cores 0-2 finish. Expect the block to stay in WAIT_CORES with no rd_en indefinitely. Asserting end_process[3] starts the unload.
- Re-arm mid-unload after 5 words. Expect out_valid=0 the next cycle, flags cleared and the counter back to 0. After all four cores complete again, the stream restarts at address 64.
- Assert resetn=0 in HOLD together with begin_process=1. Expect IDLE with all outputs 0 on the next cycle (reset has priority), and no arm taken.

Source files
------------

// File: rtl/result_unloader_pkg.sv
// rtl/result_unloader_pkg.sv - shared state encoding and default constants for the result unloader
package result_unloader_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_CORES = 3'd1,
    ISSUE      = 3'd2,
    WAIT_DATA  = 3'd3,
    HOLD       = 3'd4,
    DONE       = 3'd5
  } state_e;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'd64;
  localparam int unsigned DEFAULT_N_WORDS   = 16;

endpackage

// File: rtl/result_unloader_if.sv
// rtl/result_unloader_if.sv - data-memory read port plus host result stream
interface result_unloader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/result_unloader_core_done_tracker.sv
// rtl/result_unloader_core_done_tracker.sv - sticky per-core completion flags
module core_done_tracker #(
  parameter int unsigned N_CORES = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic [N_CORES-1:0] end_process,
  output logic               all_done
);

  logic [N_CORES-1:0] flags_q;

  // Clear wins over set, so bits raised in the arm cycle are dropped.
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_q | end_process;
    end
  end

  assign all_done = &(flags_q | end_process);

endmodule

// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - waits for all cores, then reads the result matrix and streams it to the host
module result_unloader
  import result_unloader_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       N_CORES   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int unsigned       N_WORDS   = DEFAULT_N_WORDS
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               begin_process,
  input  logic [N_CORES-1:0] end_process,
  output logic               busy,
  output logic               done,
  result_unloader_if.master  bus
);

  localparam int unsigned      CNT_W    = $clog2(N_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              all_done;

  core_done_tracker #(.N_CORES(N_CORES)) u_tracker (
    .clock       (clock),
    .resetn      (resetn),
    .clear       (begin_process),
    .end_process (end_process),
    .all_done    (all_done)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    // Arm aborts whatever is in flight, including a pending capture.
    if (begin_process) begin
      state_d = WAIT_CORES;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_CORES: if (all_done) state_d = ISSUE;
        ISSUE: state_d = WAIT_DATA;
        WAIT_DATA: begin
          out_data_d = bus.rd_data;
          state_d    = HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (count_q == LAST_CNT) begin
              state_d = DONE;
            end else begin
              count_d = count_q + 1'b1;
              state_d = ISSUE;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rd_en     = (state_q == ISSUE);
  assign bus.rd_addr   = BASE_ADDR + ADDR_W'(count_q);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_last  = (state_q == HOLD) && (count_q == LAST_CNT);
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - randomized self-checking bench for result_unloader
module tb_result_unloader;

  localparam int          N_WORDS = 16;
  localparam logic [15:0] BASE    = 16'd64;
  localparam int M_IDLE = 0, M_WAIT = 1, M_UNL = 2, M_DONE = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       begin_process = 1'b0;
  logic [3:0] end_process = 4'h0;
  logic       busy, done;

  result_unloader_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  result_unloader #(
    .DATA_W(16), .ADDR_W(16), .N_CORES(4), .BASE_ADDR(16'd64), .N_WORDS(16)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .begin_process (begin_process),
    .end_process   (end_process),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory answers one cycle after rd_en; garbage otherwise.
  logic [15:0] mem [0:255];
  always @(posedge clock) bus.rd_data <= bus.rd_en ? mem[bus.rd_addr[7:0]] : 16'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int          m_mode = M_IDLE;
  logic [3:0]  m_flags = 4'h0;
  int          m_k = 0;
  int          m_rd_cyc = 0;
  bit          m_on = 0;
  bit          m_fresh = 0;
  int          rd_cycles[$];
  logic [15:0] rd_addrs[$];
  logic [15:0] hs_data[$];
  bit          hs_last[$];
  int          hs_cyc[$];

  always @(negedge clock) begin
    bit e_rd, e_v;
    if (m_on) begin
      e_rd = (m_mode == M_UNL) && (cyc == m_rd_cyc);
      e_v  = (m_mode == M_UNL) && (cyc >= m_rd_cyc + 2);
      chk("rd_en", 32'(bus.rd_en), 32'(e_rd));
      chk("out_valid", 32'(bus.out_valid), 32'(e_v));
      chk("out_last", 32'(bus.out_last), 32'(e_v && m_k == N_WORDS - 1));
      chk("busy", 32'(busy), 32'(m_mode == M_WAIT || m_mode == M_UNL));
      chk("done", 32'(done), 32'(m_mode == M_DONE));
      if (e_rd) chk("rd_addr", 32'(bus.rd_addr), 32'(16'(BASE + m_k)));
      if (e_v) chk("out_data", 32'(bus.out_data), 32'(mem[8'(BASE + m_k)]));
      if (m_fresh) chk("out_data_after_reset", 32'(bus.out_data), 32'h0);
    end
    if (bus.rd_en === 1'b1) begin
      rd_cycles.push_back(cyc);
      rd_addrs.push_back(bus.rd_addr);
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      hs_data.push_back(bus.out_data);
      hs_last.push_back(bus.out_last);
      hs_cyc.push_back(cyc);
    end
    if (resetn === 1'b0) begin
      m_on = 1; m_mode = M_IDLE; m_flags = 4'h0; m_k = 0; m_fresh = 1;
    end else if (m_on) begin
      if (begin_process) begin
        m_mode = M_WAIT; m_flags = 4'h0; m_k = 0; m_fresh = 0;
      end else begin
        m_flags = m_flags | end_process;
        if (m_mode == M_WAIT && &m_flags) begin
          m_mode = M_UNL; m_rd_cyc = cyc + 1;
        end else if (m_mode == M_UNL) begin
          if (cyc == m_rd_cyc + 1) m_fresh = 0;
          if (cyc >= m_rd_cyc + 2 && bus.out_ready) begin
            if (m_k == N_WORDS - 1) m_mode = M_DONE;
            else begin
              m_k++; m_rd_cyc = cyc + 1;
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    rd_cycles.delete(); rd_addrs.delete(); hs_data.delete(); hs_last.delete(); hs_cyc.delete();
  endtask

  task automatic arm();
    begin_process = 1'b1;
    tick(1);
    begin_process = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] v);
    end_process = v;
    tick(1);
    end_process = 4'h0;
    tick(1);
  endtask

  task automatic wait_words(input int n, input int budget);
    int t = 0;
    while (hs_data.size() < n && t < budget) begin tick(1); t++; end
    chk("wait_words_timeout", 32'(hs_data.size() >= n), 32'h1);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin tick(1); t++; end
    chk("wait_done_timeout", 32'(done), 32'h1);
  endtask

  task automatic wait_valid(input int budget);
    int t = 0;
    while (bus.out_valid !== 1'b1 && t < budget) begin tick(1); t++; end
    chk("wait_valid_timeout", 32'(bus.out_valid), 32'h1);
  endtask

  initial begin
    int arm_cyc, n_rd;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int k = 0; k < N_WORDS; k++) mem[64 + k] = 16'(k * 3);
    bus.out_ready = 1'b0;
    tick(3);
    chk("reset_rd_en", 32'(bus.rd_en), 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_out_data", 32'(bus.out_data), 32'h0);
    chk("reset_out_last", 32'(bus.out_last), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_rd_addr", 32'(bus.rd_addr), 32'd64);
    resetn = 1'b1;
    tick(2);

    // Pulsed completions, sink always ready.
    clear_logs();
    bus.out_ready = 1'b1;
    arm();
    pulse(4'b0001); pulse(4'b0010); pulse(4'b0100); pulse(4'b1000);
    wait_done(200);
    chk("t1_words", 32'(hs_data.size()), 32'd16);
    for (int k = 0; k < 16 && k < hs_data.size(); k++) begin
      chk("t1_data", 32'(hs_data[k]), 32'(k * 3));
      chk("t1_last", 32'(hs_last[k]), 32'(k == 15));
    end
    for (int k = 0; k < 16 && k < rd_addrs.size(); k++) chk("t1_addr", 32'(rd_addrs[k]), 32'(64 + k));
    chk("t1_busy", 32'(busy), 32'h0);

    // Level completion one cycle after arm: latency pins.
    clear_logs();
    begin_process = 1'b1;
    arm_cyc = cyc;
    tick(1);
    begin_process = 1'b0;
    end_process = 4'hF;
    wait_done(200);
    end_process = 4'h0;
    if (rd_cycles.size() > 0) chk("t2_first_rd", 32'(rd_cycles[0] - arm_cyc), 32'd2);
    else chk("t2_no_rd", 32'h0, 32'h1);
    if (hs_cyc.size() > 0) chk("t2_first_valid", 32'(hs_cyc[0] - arm_cyc), 32'd4);
    else chk("t2_no_valid", 32'h0, 32'h1);

    // Backpressure on word 2.
    clear_logs();
    arm();
    pulse(4'hF);
    wait_words(2, 100);
    bus.out_ready = 1'b0;
    wait_valid(20);
    n_rd = rd_cycles.size();
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_data", 32'(bus.out_data), 32'd6);
      chk("t3_stall_valid", 32'(bus.out_valid), 32'h1);
      chk("t3_stall_rd", 32'(rd_cycles.size()), 32'(n_rd));
      tick(1);
    end
    chk("t3_reads_before_release", 32'(n_rd), 32'd3);
    bus.out_ready = 1'b1;
    wait_done(200);
    chk("t3_words", 32'(hs_data.size()), 32'd16);

    // Missing core 3 blocks the unload.
    clear_logs();
    arm();
    pulse(4'b0001); pulse(4'b0010); pulse(4'b0100);
    tick(40);
    chk("t4_no_rd", 32'(rd_cycles.size()), 32'h0);
    chk("t4_busy", 32'(busy), 32'h1);
    pulse(4'b1000);
    wait_done(200);
    chk("t4_words", 32'(hs_data.size()), 32'd16);

    // Re-arm mid-unload.
    clear_logs();
    arm();
    pulse(4'hF);
    wait_words(5, 100);
    arm();
    chk("t5_valid_dropped", 32'(bus.out_valid), 32'h0);
    clear_logs();
    tick(3);
    chk("t5_no_rd_before_flags", 32'(rd_cycles.size()), 32'h0);
    pulse(4'b1000); pulse(4'b0100); pulse(4'b0010); pulse(4'b0001);
    wait_done(200);
    if (rd_addrs.size() > 0) chk("t5_restart_addr", 32'(rd_addrs[0]), 32'd64);
    else chk("t5_no_rd", 32'h0, 32'h1);
    chk("t5_words", 32'(hs_data.size()), 32'd16);

    // Reset and arm together while holding a word.
    arm();
    pulse(4'hF);
    bus.out_ready = 1'b0;
    wait_valid(20);
    resetn = 1'b0;
    begin_process = 1'b1;
    tick(1);
    resetn = 1'b1;
    begin_process = 1'b0;
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_done", 32'(done), 32'h0);
    chk("t6_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_rd_en", 32'(bus.rd_en), 32'h0);
    chk("t6_data", 32'(bus.out_data), 32'h0);
    chk("t6_addr", 32'(bus.rd_addr), 32'd64);
    tick(5);
    chk("t6_no_arm", 32'(busy), 32'h0);

    // Randomized rounds; the per-cycle model does the checking.
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N_WORDS; k++) mem[64 + k] = 16'($urandom);
      arm();
      for (int t = 0; t < 400 && done !== 1'b1; t++) begin
        end_process   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        bus.out_ready = 1'($urandom_range(0, 1));
        begin_process = ($urandom_range(0, 299) == 0);
        resetn        = ($urandom_range(0, 999) != 0);
        tick(1);
      end
      end_process = 4'h0;
      begin_process = 1'b0;
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
